// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller, with a read-tag FIFO that
// routes pipelined responses. Define SDRAM_ARB_PRIO_EN for m0 strict priority (default round-robin).
module sdram_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned HOLD_MAX    = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                rsp_err
);

`ifdef SDRAM_ARB_PRIO_EN
  localparam bit PrioEn = 1'b1;
`else
  localparam bit PrioEn = 1'b0;
`endif
  localparam int unsigned PtrW  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_PENDING + 1);
  localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [MAX_PENDING-1:0] tag_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic                   rsp_err_q;

  logic req0, req1, full, empty, accept, push, pop, head, hold_limit;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_PENDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign full       = (cnt_q == CntW'(MAX_PENDING));
  assign empty      = (cnt_q == '0);
  assign hold_limit = (hold_q >= HoldW'(HOLD_MAX - 1));

  // Slave-side mux; a full tag FIFO blocks reads only, writes still flow.
  always_comb begin
    s_address      = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      StGnt0: begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_read         = m0_read & ~full;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest | (m0_read & full);
      end
      StGnt1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read & ~full;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest | (m1_read & full);
      end
      default: ;
    endcase
  end

  assign accept           = (s_read | s_write) & ~s_waitrequest;
  assign push             = accept & s_read;
  assign pop              = s_readdatavalid & ~empty;
  assign head             = tag_q[rd_ptr_q];
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign rsp_err          = rsp_err_q;

  // Grant only moves when the holder is not mid-stall: it dropped its request or was accepted.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (req0 && (!req1 || PrioEn || last_q)) state_d = StGnt0;
        else if (req1)                           state_d = StGnt1;
      end
      StGnt0: begin
        if (!req0)                                            state_d = req1 ? StGnt1 : StIdle;
        else if (accept && req1 && !PrioEn && hold_limit)     state_d = StGnt1;
      end
      StGnt1: begin
        if (!req1)                                            state_d = req0 ? StGnt0 : StIdle;
        else if (accept && req0 && (PrioEn || hold_limit))    state_d = StGnt0;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_q != StIdle) last_d = (state_q == StGnt1);
    end else if (accept && hold_q != HoldW'(HOLD_MAX)) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= (state_q == StGnt1);
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
      if (s_readdatavalid && empty) rsp_err_q <= 1'b1;
    end
  end

endmodule
